// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned INSTR_W     = 32;
    localparam logic [5:0]  HALT_OPCODE = 6'h3F;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        HOLD,
        HALTED
    } fetch_state_t;

    function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
        return instr[31:26] == HALT_OPCODE;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding a fetched word and its pc+4 while decode stalls.
module fetch_skid_buf
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               drain,
    input  logic               flush,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [31:0]        load_pc4,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [31:0]        pc4
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            instr <= '0;
            pc4   <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= load_instr;
            pc4   <= load_pc4;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// MIPS instruction fetch stage: PC, single-outstanding imem requests, IF/ID register.
// Optional feature: define FETCH_HALT_EN to stop fetching on the HALT opcode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ready,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic               if_id_valid,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [31:0]        if_id_pc4,
    output logic               halted
);

    fetch_state_t       state, state_n;
    logic [31:0]        pc, pc_n;
    logic               kill, kill_n;
    logic               load_ifid, clr_ifid;
    logic [INSTR_W-1:0] ld_instr;
    logic [31:0]        ld_pc4;
    logic               buf_load, buf_drain, buf_flush;
    logic               buf_valid;
    logic [INSTR_W-1:0] buf_instr;
    logic [31:0]        buf_pc4;

    assign imem_req  = (state == FETCH);
    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FETCH;
            pc    <= RESET_PC;
            kill  <= 1'b0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            kill  <= kill_n;
        end
    end

    // pc is advanced on acceptance, so while in WAIT it already equals the word's pc+4.
    always_comb begin
        state_n   = state;
        pc_n      = pc;
        kill_n    = kill;
        load_ifid = 1'b0;
        clr_ifid  = 1'b0;
        ld_instr  = imem_rdata;
        ld_pc4    = pc;
        buf_load  = 1'b0;
        buf_drain = 1'b0;
        buf_flush = 1'b0;
        if (redirect) begin
            pc_n      = {redirect_pc[31:2], 2'b00};
            clr_ifid  = 1'b1;
            buf_flush = 1'b1;
            state_n   = FETCH;
            kill_n    = 1'b0;
            if ((state == WAIT && !imem_rvalid) || (state == FETCH && imem_ready)) begin
                kill_n  = 1'b1;
                state_n = WAIT;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ready) begin
                        pc_n    = pc + 32'd4;
                        state_n = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (kill) begin
                            kill_n  = 1'b0;
                            state_n = FETCH;
                        end else if (!if_id_valid || !stall) begin
                            load_ifid = 1'b1;
                            state_n   = FETCH;
                        end else begin
                            buf_load = 1'b1;
                            state_n  = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!stall && buf_valid) begin
                        load_ifid = 1'b1;
                        ld_instr  = buf_instr;
                        ld_pc4    = buf_pc4;
                        buf_drain = 1'b1;
                        state_n   = FETCH;
                    end
                end
                HALTED: ;
                default: state_n = FETCH;
            endcase
`ifdef FETCH_HALT_EN
            if (load_ifid && is_halt(ld_instr)) begin
                state_n = HALTED;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_id_valid <= 1'b0;
            if_id_instr <= '0;
            if_id_pc4   <= '0;
        end else if (clr_ifid) begin
            if_id_valid <= 1'b0;
        end else if (load_ifid) begin
            if_id_valid <= 1'b1;
            if_id_instr <= ld_instr;
            if_id_pc4   <= ld_pc4;
        end else if (!stall) begin
            if_id_valid <= 1'b0;
        end
    end

`ifdef FETCH_HALT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halted <= 1'b0;
        end else begin
            halted <= (state_n == HALTED);
        end
    end
`else
    assign halted = 1'b0;
`endif

    fetch_skid_buf u_skid (
        .clk        (clk),
        .rst        (rst),
        .load       (buf_load),
        .drain      (buf_drain),
        .flush      (buf_flush),
        .load_instr (imem_rdata),
        .load_pc4   (pc),
        .valid      (buf_valid),
        .instr      (buf_instr),
        .pc4        (buf_pc4)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run scored
// against an in-order instruction-stream model with a latency-randomized memory.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_ready, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        stall, redirect;
    logic [31:0] redirect_pc;
    logic        if_id_valid, halted;
    logic [31:0] if_id_instr, if_id_pc4;

    logic        w_req, w_ready, w_rvalid, w_valid, w_halted;
    logic [31:0] w_addr, w_rdata, w_instr, w_pc4;

    int errors = 0;
    int checks = 0;

    bit          mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;
    int          lat_min, lat_max;
    bit          rand_ready;
    logic [31:0] exp_pc;
    int          delivered;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_id_valid (if_id_valid),
        .if_id_instr (if_id_instr),
        .if_id_pc4   (if_id_pc4),
        .halted      (halted)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (w_req),
        .imem_addr   (w_addr),
        .imem_ready  (w_ready),
        .imem_rvalid (w_rvalid),
        .imem_rdata  (w_rdata),
        .stall       (1'b0),
        .redirect    (1'b0),
        .redirect_pc (32'h0000_0000),
        .if_id_valid (w_valid),
        .if_id_instr (w_instr),
        .if_id_pc4   (w_pc4),
        .halted      (w_halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] h;
        if (a == 32'h0000_0000) return 32'h2008_0005;
        if (a == 32'h0000_0300) return 32'hFC00_0000;
        h = (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
        return {1'b0, h[30:0]};
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, "_req"},   32'(imem_req), 32'd1);
        chk({tag, "_addr"},  imem_addr, 32'h0000_0000);
        chk({tag, "_valid"}, 32'(if_id_valid), 32'd0);
        chk({tag, "_instr"}, if_id_instr, 32'h0000_0000);
        chk({tag, "_pc4"},   if_id_pc4, 32'h0000_0000);
        chk({tag, "_halted"}, 32'(halted), 32'd0);
    endtask

    // One clock: called and returning at a negedge; inputs for the coming edge already set.
    task automatic tick();
        logic        s_req, s_acc, s_rv, s_redir, consume;
        logic [31:0] s_addr, s_rpc, c_instr, c_pc4;
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_acc   = imem_req && imem_ready;
        s_rv    = imem_rvalid;
        s_redir = redirect;
        s_rpc   = redirect_pc;
        consume = if_id_valid && !stall && !redirect;
        c_instr = if_id_instr;
        c_pc4   = if_id_pc4;
        if (consume) begin
            chk("stream_pc4", c_pc4, exp_pc + 32'd4);
            chk("stream_instr", c_instr, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            delivered++;
        end
        @(posedge clk);
        if (s_rv) mem_busy = 1'b0;
        else if (mem_busy) mem_cnt--;
        if (s_acc) begin
            mem_busy = 1'b1;
            mem_cnt  = int'($urandom_range(lat_max, lat_min)) - 1;
            mem_addr = s_addr;
        end
        if (s_redir) exp_pc = {s_rpc[31:2], 2'b00};
        @(negedge clk);
        redirect    = 1'b0;
        imem_rvalid = mem_busy && (mem_cnt == 0);
        imem_rdata  = imem_rvalid ? mem_word(mem_addr) : $urandom;
        imem_ready  = rand_ready ? 1'($urandom_range(1, 0)) : 1'b1;
        if (s_redir) chk("redirect_clears_ifid", 32'(if_id_valid), 32'd0);
        if (s_req && !s_acc && !s_redir && imem_req) chk("addr_stable", imem_addr, s_addr);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        w_ready = 1'b1; w_rvalid = 1'b0; w_rdata = '0;
        mem_busy = 1'b0; mem_cnt = 0; mem_addr = '0;
        lat_min = 1; lat_max = 1; rand_ready = 1'b0; exp_pc = '0; delivered = 0;

        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        chk("wrap_reset_addr", w_addr, 32'hFFFF_FFFC);

        // First fetch: accept at 0, word back next cycle, IF/ID the cycle after.
        rst = 1'b1;
        tick();
        chk("wait_no_req", 32'(imem_req), 32'd0);
        w_rvalid = 1'b1; w_rdata = 32'h1234_5678;
        tick();
        w_rvalid = 1'b0;
        chk("first_valid", 32'(if_id_valid), 32'd1);
        chk("first_instr", if_id_instr, 32'h2008_0005);
        chk("first_pc4", if_id_pc4, 32'h0000_0004);
        chk("wrap_addr", w_addr, 32'h0000_0000);
        chk("wrap_req", 32'(w_req), 32'd1);
        chk("wrap_pc4", w_pc4, 32'h0000_0000);
        chk("wrap_instr", w_instr, 32'h1234_5678);

        // Stall while the next word arrives: skid buffer, no new request.
        stall = 1'b1;
        tick();
        tick();
        chk("hold_no_req", 32'(imem_req), 32'd0);
        chk("hold_ifid_pc4", if_id_pc4, 32'h0000_0004);
        tick();
        chk("hold_no_req2", 32'(imem_req), 32'd0);
        chk("hold_ifid_valid", 32'(if_id_valid), 32'd1);
        chk("hold_ifid_instr", if_id_instr, 32'h2008_0005);
        stall = 1'b0;
        tick();
        chk("drain_pc4", if_id_pc4, 32'h0000_0008);
        chk("drain_instr", if_id_instr, mem_word(32'h4));
        chk("drain_req", 32'(imem_req), 32'd1);
        chk("drain_addr", imem_addr, 32'h0000_0008);

        // Redirect while waiting; stale response arrives two cycles later.
        lat_min = 3; lat_max = 3;
        tick();
        chk("t3_wait", 32'(imem_req), 32'd0);
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        tick();
        tick();
        chk("kill_no_req", 32'(imem_req), 32'd0);
        tick();
        chk("kill_valid", 32'(if_id_valid), 32'd0);
        chk("kill_req", 32'(imem_req), 32'd1);
        chk("kill_addr", imem_addr, 32'h0000_0100);
        lat_min = 1; lat_max = 1;

        // Redirect together with stall on a live IF/ID.
        for (int n = 0; n < 20 && !if_id_valid; n++) tick();
        chk("t4_reach_valid", 32'(if_id_valid), 32'd1);
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0200;
        tick();
        chk("stall_redirect_valid", 32'(if_id_valid), 32'd0);
        stall = 1'b0;

        // HALT opcode at 0x300.
        redirect = 1'b1; redirect_pc = 32'h0000_0300;
        tick();
        for (int n = 0; n < 20 && !(if_id_valid && if_id_pc4 == 32'h304); n++) tick();
        chk("halt_word", if_id_instr, 32'hFC00_0000);
`ifdef FETCH_HALT_EN
        chk("halt_flag", 32'(halted), 32'd1);
        chk("halt_no_req", 32'(imem_req), 32'd0);
        repeat (3) tick();
        chk("halt_stays", 32'(halted), 32'd1);
        chk("halt_no_req2", 32'(imem_req), 32'd0);
        redirect = 1'b1; redirect_pc = 32'h0000_0040;
        tick();
        chk("unhalt_flag", 32'(halted), 32'd0);
        chk("unhalt_req", 32'(imem_req), 32'd1);
        chk("unhalt_addr", imem_addr, 32'h0000_0040);
`else
        chk("nohalt_flag", 32'(halted), 32'd0);
        chk("nohalt_req", 32'(imem_req), 32'd1);
        chk("nohalt_addr", imem_addr, 32'h0000_0304);
`endif

        // Randomized run against the in-order stream model.
        redirect = 1'b1; redirect_pc = 32'h0000_1000;
        tick();
        rand_ready = 1'b1; lat_min = 1; lat_max = 3; delivered = 0;
        for (int i = 0; i < 3000; i++) begin
            stall = ($urandom_range(9, 0) < 3);
            if ($urandom_range(39, 0) == 0) begin
                redirect    = 1'b1;
                redirect_pc = ($urandom & 32'h7FFF_FFFF) | 32'h0001_0000;
            end
            tick();
            chk("never_halted", 32'(halted), 32'd0);
        end
        stall = 1'b0; rand_ready = 1'b0;
        chk("random_progress", 32'(delivered >= 150), 32'd1);

        // Asynchronous reset in the middle of a WAIT.
        lat_min = 3; lat_max = 3;
        for (int n = 0; n < 20 && imem_req; n++) tick();
        chk("t7_in_wait", 32'(imem_req), 32'd0);
        rst = 1'b0;
        #1;
        check_reset_vals("midwait_reset");
        mem_busy = 1'b0; imem_rvalid = 1'b0; imem_ready = 1'b1; exp_pc = '0;
        @(negedge clk);
        rst = 1'b1;
        for (int n = 0; n < 20 && !if_id_valid; n++) tick();
        chk("post_reset_instr", if_id_instr, 32'h2008_0005);
        chk("post_reset_pc4", if_id_pc4, 32'h0000_0004);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
